hpdcache_beat_upsizer: RTL

- Upstream stage of the cache's register-based FIFO buffers.
- Collects narrow data beats from a memory response channel into one wide entry (a cache line or a fraction of one).
- Pushes each completed entry into the FIFO through its write/write-ok (w/wok) handshake.
- Supports early termination, using a last flag, for short bursts.

---
 rtl/hpdcache_beat_upsizer.sv | 92 +++++++++
 1 files changed

// File: rtl/hpdcache_beat_upsizer.sv
// Packs narrow beats into one wide entry and pushes it through the w/wok handshake.
// Entry is presented one cycle after its final beat; while it is held, in_ready_o follows out_wok_i.
`timescale 1ns/1ps
module hpdcache_beat_upsizer #(
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned RATIO  = 4,
    parameter int unsigned CNT_W  = $clog2(RATIO + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [BEAT_W-1:0]         in_data_i,
    input  logic                      in_last_i,
    output logic                      out_w_o,
    input  logic                      out_wok_i,
    output logic [BEAT_W*RATIO-1:0]   out_wdata_o,
    output logic [CNT_W-1:0]          out_beats_o
);

    localparam int unsigned IDX_W = $clog2(RATIO);

    typedef enum logic {FILL, FULL} state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               cnt_q, cnt_d, wr_idx;
    logic [CNT_W-1:0]               beats_q, beats_d;
    logic [RATIO-1:0][BEAT_W-1:0]   data_q, data_d;
    logic                           accept, done;

    assign in_ready_o  = (state_q == FILL) || out_wok_i;
    assign out_w_o     = (state_q == FULL);
    assign out_wdata_o = data_q;
    assign out_beats_o = beats_q;
    assign accept      = in_valid_i && in_ready_o;

    // A beat accepted while the held entry drains always starts a fresh entry at slot 0.
    assign wr_idx = (state_q == FULL) ? '0 : cnt_q;
    assign done   = in_last_i || (wr_idx == IDX_W'(RATIO - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        data_d  = data_q;

        if (state_q == FULL && out_wok_i) begin
            state_d = FILL;
            cnt_d   = '0;
        end

        if (accept) begin
            if (wr_idx == '0) begin
                data_d = '0;
            end
            data_d[wr_idx] = in_data_i;
            if (done) begin
                state_d = FULL;
                beats_d = CNT_W'(wr_idx) + CNT_W'(1);
                cnt_d   = '0;
            end else begin
                cnt_d = wr_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            beats_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            data_q  <= data_d;
        end
    end

`ifndef SYNTHESIS
    hold_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_w_o && !out_wok_i) |=> ($stable(out_wdata_o) && $stable(out_beats_o)));

    beats_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        out_w_o |-> (out_beats_o >= CNT_W'(1) && out_beats_o <= CNT_W'(RATIO)));

    fill_ready_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == FILL) |-> in_ready_o);
`endif

endmodule
